id_stage: RTL

Instruction-decode stage of the in-order CPU; consumes the fetch stage's PC and instruction and drives its branch-redirect pair (`br_ctrl`, `ID_br_pc`). It holds the IF/ID pipeline register and resolves BEQ/BNE/J in ID. It squashes the single wrong-path instruction fetched behind a taken branch. It forwards decoded operands to EX through an ID/EX register.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/id_stage_if.sv | 42 ++++
 rtl/branch_resolve.sv | 54 +++++
 rtl/id_stage.sv | 93 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the decode stage.
//   XLEN         - data/address width
//   OP_*         - opcodes resolved in ID (BEQ, BNE, J)
//   *_HI/*_LO    - instruction field ranges. The ISA documents fields MSB-first
//                  (bit 0 = MSB); here they are mapped onto [31:0] vectors, so
//                  doc field [0:5] is [31:26], [6:10] is [25:21], and so on.
//   slot_state_e - ID slot state (real instruction vs squashed bubble)
//   sext16       - sign-extend a 16-bit immediate to XLEN
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam int OP_HI   = 31;
    localparam int OP_LO   = 26;
    localparam int RS_HI   = 25;
    localparam int RS_LO   = 21;
    localparam int RT_HI   = 20;
    localparam int RT_LO   = 16;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;
    localparam int JIDX_HI = 25;
    localparam int JIDX_LO = 0;

    typedef enum logic {
        SLOT_SQUASHED = 1'b0,
        SLOT_VALID    = 1'b1
    } slot_state_e;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
        return {{(XLEN-16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: fetch / register-file / EX-side signals of the decode stage.
//   pc_in, inst_in        - fetch-stage PC and instruction
//   rs_addr, rt_addr      - register-file read addresses (from the ID slot)
//   rs_data, rt_data      - combinational register-file read data
//   br_ctrl, ID_br_pc     - fetch redirect and its target
//   ex_*                  - ID/EX register contents
//   br_taken_cnt          - saturating taken-redirect count
// Modports: slave = the decode stage, master = its environment.
interface id_stage_if;
    import cpu_pkg::*;

    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] inst_in;
    logic [4:0]      rs_addr;
    logic [4:0]      rt_addr;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic            br_ctrl;
    logic [XLEN-1:0] ID_br_pc;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_inst;
    logic [XLEN-1:0] ex_rs_data;
    logic [XLEN-1:0] ex_rt_data;
    logic [XLEN-1:0] ex_imm;
    logic [15:0]     br_taken_cnt;

    modport slave (
        input  pc_in, inst_in, rs_data, rt_data,
        output rs_addr, rt_addr, br_ctrl, ID_br_pc,
               ex_valid, ex_pc, ex_inst, ex_rs_data, ex_rt_data, ex_imm,
               br_taken_cnt
    );

    modport master (
        output pc_in, inst_in, rs_data, rt_data,
        input  rs_addr, rt_addr, br_ctrl, ID_br_pc,
               ex_valid, ex_pc, ex_inst, ex_rs_data, ex_rt_data, ex_imm,
               br_taken_cnt
    );

endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: combinational BEQ/BNE/J resolution for the instruction in ID.
//   id_pc, id_inst    - IF/ID register contents
//   rs_data, rt_data  - register operands for the compare
//   id_valid          - slot holds a real instruction (squashed slots never take)
//   taken             - redirect fetch
//   target            - redirect address (0 for non-branch opcodes)
module branch_resolve
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_inst,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            id_valid,
    output logic            taken,
    output logic [XLEN-1:0] target
);

    logic [5:0]      opcode;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] j_tgt;
    logic            cond;

    assign opcode = id_inst[OP_HI:OP_LO];
    assign seq_pc = id_pc + 32'd4;
    // Both sums wrap modulo 2^32 by construction.
    assign br_tgt = seq_pc + (sext16(id_inst[IMM_HI:IMM_LO]) << 2);
    // J keeps the top nibble of the sequential PC (region-relative jump).
    assign j_tgt  = {seq_pc[31:28], id_inst[JIDX_HI:JIDX_LO], 2'b00};

    always_comb begin
        cond   = 1'b0;
        target = '0;
        case (opcode)
            OP_BEQ: begin
                cond   = (rs_data == rt_data);
                target = br_tgt;
            end
            OP_BNE: begin
                cond   = (rs_data != rt_data);
                target = br_tgt;
            end
            OP_J: begin
                cond   = 1'b1;
                target = j_tgt;
            end
            default: ;
        endcase
    end

    assign taken = id_valid & cond;

endmodule

// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the in-order CPU.
//   clk, reset - rising-edge clock, asynchronous active-high reset
//   bus        - id_stage_if.slave (fetch inputs, register-file port,
//                redirect pair, ID/EX register outputs, taken counter)
// Holds the IF/ID and ID/EX registers, resolves BEQ/BNE/J in ID, and squashes
// the one wrong-path instruction fetched behind a taken redirect.
module id_stage
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    id_stage_if.slave  bus
);

    slot_state_e     slot_q;
    slot_state_e     slot_d;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_inst;
    logic            taken;
    logic [XLEN-1:0] target;
    logic [15:0]     taken_cnt;

    // ID slot state: the instruction fetched while a redirect is asserted is
    // wrong-path, so the slot it lands in becomes a bubble for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) slot_q <= SLOT_SQUASHED;
        else       slot_q <= slot_d;
    end

    always_comb begin
        slot_d = SLOT_VALID;
        if (taken) slot_d = SLOT_SQUASHED;
    end

    assign id_valid = (slot_q == SLOT_VALID);

    // IF/ID register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_pc   <= '0;
            id_inst <= '0;
        end else begin
            id_pc   <= bus.pc_in;
            id_inst <= bus.inst_in;
        end
    end

    assign bus.rs_addr = id_inst[RS_HI:RS_LO];
    assign bus.rt_addr = id_inst[RT_HI:RT_LO];

    branch_resolve u_br (
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .rs_data  (bus.rs_data),
        .rt_data  (bus.rt_data),
        .id_valid (id_valid),
        .taken    (taken),
        .target   (target)
    );

    // Reset clears id_valid asynchronously, so a pending redirect drops at once.
    assign bus.br_ctrl  = taken;
    assign bus.ID_br_pc = taken ? target : '0;

    // ID/EX register; branches flow on to EX as ordinary instructions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ex_valid   <= 1'b0;
            bus.ex_pc      <= '0;
            bus.ex_inst    <= '0;
            bus.ex_rs_data <= '0;
            bus.ex_rt_data <= '0;
            bus.ex_imm     <= '0;
        end else begin
            bus.ex_valid   <= id_valid;
            bus.ex_pc      <= id_pc;
            bus.ex_inst    <= id_inst;
            bus.ex_rs_data <= bus.rs_data;
            bus.ex_rt_data <= bus.rt_data;
            bus.ex_imm     <= sext16(id_inst[IMM_HI:IMM_LO]);
        end
    end

    // Saturating taken-redirect counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            taken_cnt <= '0;
        else if (taken && taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
    end

    assign bus.br_taken_cnt = taken_cnt;

endmodule
